// File: rtl/mux_select_sequencer.sv
// ---------------------------------------------------------------------------
// mux_select_sequencer
//
// Control stage in front of a 4:1 multiplexer. Four sources (A..D) request
// the mux; a round-robin arbiter picks one, drives the {CTRL1,CTRL2} select
// pair, waits one settle cycle when the select actually changes, and then
// holds the selection for a programmable dwell while flagging VALID.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   EN         in   sequencer enable; low returns to IDLE
//   REQ[3:0]   in   per-source request (bit0=A .. bit3=D)
//   DWELL      in   hold time in cycles, sampled at each grant (0 acts as 1)
//   CTRL1      out  mux select MSB
//   CTRL2      out  mux select LSB ({CTRL1,CTRL2}: 00=A 01=B 10=C 11=D)
//   GRANT[3:0] out  one-hot granted source, zero when idle
//   VALID      out  mux output settled and selection stable
//   SWITCH     out  one-cycle pulse on the edge the select value changes
//   DBG_STATE  out  current FSM state (IDLE=0, SETTLE=1, HOLD=2)
//
// There is no valid/ready handshake here: REQ is a level request that the
// source keeps asserted for as long as it wants the mux; dropping it while
// granted releases the mux at the next edge.
// ---------------------------------------------------------------------------
module mux_select_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic [3:0]         REQ,
    input  logic [DWELL_W-1:0] DWELL,
    output logic               CTRL1,
    output logic               CTRL2,
    output logic [3:0]         GRANT,
    output logic               VALID,
    output logic               SWITCH,
    output logic [1:0]         DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Registered state
    state_t               r_state;
    logic [1:0]           r_ptr;
    logic [DWELL_W-1:0]   r_cnt;     // VALID cycles remaining, including the current one
    logic [1:0]           r_ctrl;
    logic [3:0]           r_grant;
    logic                 r_valid;
    logic                 r_switch;

    // Next-state values
    state_t               w_nxt_state;
    logic [1:0]           w_nxt_ptr;
    logic [DWELL_W-1:0]   w_nxt_cnt;
    logic [1:0]           w_nxt_ctrl;
    logic [3:0]           w_nxt_grant;
    logic                 w_nxt_valid;
    logic                 w_nxt_switch;

    // Arbitration helpers
    logic [1:0]           w_win;
    logic                 w_any;
    logic                 w_gnt_req;
    logic                 w_arb;
    logic [DWELL_W-1:0]   w_load;
    logic [1:0]           w_idx;

    assign w_any     = |REQ;
    // While granted, r_ctrl is the granted source index.
    assign w_gnt_req = REQ[r_ctrl];
    assign w_load    = (DWELL == '0) ? DWELL_W'(1) : DWELL;

    // Round-robin search PTR+1, PTR+2, PTR+3, PTR. Walking from the farthest
    // offset down lets the nearest set bit overwrite the result last.
    always_comb begin
        w_win = r_ptr + 2'd1;
        w_idx = '0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (REQ[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Next-state / output logic
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ptr    = r_ptr;
        w_nxt_cnt    = r_cnt;
        w_nxt_ctrl   = r_ctrl;
        w_nxt_grant  = r_grant;
        w_nxt_valid  = r_valid;
        w_nxt_switch = 1'b0;
        w_arb        = 1'b0;

        case (r_state)
            IDLE: begin
                w_nxt_grant = 4'b0000;
                w_nxt_valid = 1'b0;
                if (EN && w_any) begin
                    w_arb = 1'b1;
                end
            end

            SETTLE: begin
                if (!EN || !w_gnt_req) begin
                    w_nxt_state = IDLE;
                    w_nxt_grant = 4'b0000;
                    w_nxt_valid = 1'b0;
                end else begin
                    w_nxt_state = HOLD;
                    w_nxt_valid = 1'b1;
                end
            end

            HOLD: begin
                if (!EN) begin
                    w_nxt_state = IDLE;
                    w_nxt_grant = 4'b0000;
                    w_nxt_valid = 1'b0;
                end else if (!w_gnt_req || (r_cnt <= DWELL_W'(1))) begin
                    // Dwell over (or released early): re-arbitrate this edge.
                    if (w_any) begin
                        w_arb = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_grant = 4'b0000;
                        w_nxt_valid = 1'b0;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - DWELL_W'(1);
                end
            end

            default: begin
                w_nxt_state = IDLE;
                w_nxt_grant = 4'b0000;
                w_nxt_valid = 1'b0;
            end
        endcase

        if (w_arb) begin
            w_nxt_ptr   = w_win;
            w_nxt_cnt   = w_load;
            w_nxt_grant = 4'b0001 << w_win;
            if (w_win != r_ctrl) begin
                // Select changes: the mux needs a settle cycle before VALID.
                w_nxt_ctrl   = w_win;
                w_nxt_switch = 1'b1;
                w_nxt_state  = SETTLE;
                w_nxt_valid  = 1'b0;
            end else begin
                // Select already there: go straight to HOLD, VALID continuous.
                w_nxt_state = HOLD;
                w_nxt_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd3;
            r_cnt    <= '0;
            r_ctrl   <= 2'b00;
            r_grant  <= 4'b0000;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_ptr    <= w_nxt_ptr;
            r_cnt    <= w_nxt_cnt;
            r_ctrl   <= w_nxt_ctrl;
            r_grant  <= w_nxt_grant;
            r_valid  <= w_nxt_valid;
            r_switch <= w_nxt_switch;
        end
    end

    assign CTRL1     = r_ctrl[1];
    assign CTRL2     = r_ctrl[0];
    assign GRANT     = r_grant;
    assign VALID     = r_valid;
    assign SWITCH    = r_switch;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_select_sequencer
//
// Directed bench for mux_select_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, so each check sees
// the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_mux_select_sequencer;

    localparam int DWELL_W = 8;

    // Clock / reset
    logic               clk;
    logic               rst_n;

    // DUT signals
    logic               en;
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic               ctrl1;
    logic               ctrl2;
    logic [3:0]         grant;
    logic               valid;
    logic               switch_p;
    logic [1:0]         dbg_state;

    int n_tests;
    int n_fail;

    mux_select_sequencer #(.DWELL_W(DWELL_W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .EN        (en),
        .REQ       (req),
        .DWELL     (dwell),
        .CTRL1     (ctrl1),
        .CTRL2     (ctrl2),
        .GRANT     (grant),
        .VALID     (valid),
        .SWITCH    (switch_p),
        .DBG_STATE (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the sequence is fixed-length, so this only fires on a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] e_ctrl, input logic [3:0] e_grant,
                       input logic e_valid, input logic e_switch);
        cmp({tag, ".ctrl"},   8'({ctrl1, ctrl2}), 8'(e_ctrl));
        cmp({tag, ".grant"},  8'(grant),          8'(e_grant));
        cmp({tag, ".valid"},  8'(valid),          8'(e_valid));
        cmp({tag, ".switch"}, 8'(switch_p),       8'(e_switch));
    endtask

    // Assert reset asynchronously (mid-cycle), check outputs before any edge,
    // then release 1 unit after the next rising edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk(tag, 2'b00, 4'b0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    logic [1:0] code;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---- reset at t=0, no clock edge yet ----
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        dwell = '0;
        #2;
        chk("reset_t0", 2'b00, 4'b0000, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // ---- single source B, DWELL=3 ----
        en = 1'b1; req = 4'b0010; dwell = 8'd3;
        step(); chk("b_e1", 2'b01, 4'b0010, 1'b0, 1'b1);   // SETTLE
        step(); chk("b_e2", 2'b01, 4'b0010, 1'b1, 1'b0);
        step(); chk("b_e3", 2'b01, 4'b0010, 1'b1, 1'b0);
        step(); chk("b_e4", 2'b01, 4'b0010, 1'b1, 1'b0);
        step(); chk("b_e5", 2'b01, 4'b0010, 1'b1, 1'b0);   // regrant same source
        step(); chk("b_e6", 2'b01, 4'b0010, 1'b1, 1'b0);

        // ---- async reset mid-HOLD, then all four requesting, DWELL=2 ----
        req = 4'b1111; dwell = 8'd2;
        do_reset("rst_mid_hold");
        // A's code equals the reset select 00, so A goes straight to HOLD
        // with no SWITCH and no settle cycle.
        step(); chk("rr_a0_e1", 2'b00, 4'b0001, 1'b1, 1'b0);
        step(); chk("rr_a0_e2", 2'b00, 4'b0001, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            code = 2'(i);   // B, C, D, then A again
            step(); chk($sformatf("rr_g%0d_sw", i),  code, 4'b0001 << code, 1'b0, 1'b1);
            step(); chk($sformatf("rr_g%0d_v1", i),  code, 4'b0001 << code, 1'b1, 1'b0);
            step(); chk($sformatf("rr_g%0d_v2", i),  code, 4'b0001 << code, 1'b1, 1'b0);
        end

        // ---- early release: REQ=0101, DWELL=10 ----
        req = 4'b0101; dwell = 8'd10;
        do_reset("rst_early");
        step(); chk("er_e1", 2'b00, 4'b0001, 1'b1, 1'b0);
        step(); chk("er_e2", 2'b00, 4'b0001, 1'b1, 1'b0);
        req = 4'b0100;
        step(); chk("er_drop", 2'b10, 4'b0100, 1'b0, 1'b1);
        step(); chk("er_hold_c", 2'b10, 4'b0100, 1'b1, 1'b0);

        // ---- EN=0 mid-HOLD on C ----
        en = 1'b0;
        step(); chk("en_off", 2'b10, 4'b0000, 1'b0, 1'b0);
        step(); chk("en_idle", 2'b10, 4'b0000, 1'b0, 1'b0);
        // PTR stays at C, so with A and C requesting the next winner is A.
        en = 1'b1; req = 4'b0101;
        step(); chk("en_rr_a", 2'b00, 4'b0001, 1'b0, 1'b1);

        // ---- DWELL=0 behaves as 1 ----
        req = 4'b0001; dwell = 8'd0;
        do_reset("rst_dw0");
        step(); chk("dw0_e1", 2'b00, 4'b0001, 1'b1, 1'b0);
        step(); chk("dw0_e2", 2'b00, 4'b0001, 1'b1, 1'b0);
        step(); chk("dw0_e3", 2'b00, 4'b0001, 1'b1, 1'b0);
        // Two requesters: each grant gets one settle cycle and one VALID cycle.
        req = 4'b0011;
        step(); chk("dw0_b_sw", 2'b01, 4'b0010, 1'b0, 1'b1);
        step(); chk("dw0_b_v",  2'b01, 4'b0010, 1'b1, 1'b0);
        step(); chk("dw0_a_sw", 2'b00, 4'b0001, 1'b0, 1'b1);
        step(); chk("dw0_a_v",  2'b00, 4'b0001, 1'b1, 1'b0);

        // ---- no requests: back to IDLE from HOLD ----
        req = 4'b0000;
        step(); chk("noreq_idle", 2'b00, 4'b0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
